// File: rtl/sha_pkg.sv
// Shared mode encodings for the SHA boolean-function pipeline.
package sha_pkg;
    localparam int MODE_W = 2;
    localparam logic [MODE_W-1:0] MODE_MAJ = 2'd0;
    localparam logic [MODE_W-1:0] MODE_CH  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_PAR = 2'd2;
    localparam logic [MODE_W-1:0] MODE_RSV = 2'd3;
endpackage

// File: rtl/sha_pipe_stage.sv
// One valid/ready register slice; loads when empty or when downstream accepts.
module sha_pipe_stage #(
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [PW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [PW-1:0] data_o
);
    logic          vld_q, vld_d;
    logic [PW-1:0] dat_q, dat_d;

    assign ready_o = !vld_q || ready_i;
    assign valid_o = vld_q;
    assign data_o  = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (ready_o) begin
            vld_d = valid_i;
            // keep last payload on bubbles so an idle output does not toggle
            if (valid_i) dat_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end
endmodule

// File: rtl/sha_bool_fn_pipe.sv
// Pipelined Maj/Ch/Parity unit with valid/ready backpressure and tag sideband.
// Define SHA_BOOLFN_PARITY_EN to build the PARITY (mode 2) function.
module sha_bool_fn_pipe
    import sha_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [0:W-1]      in_a,
    input  logic [0:W-1]      in_b,
    input  logic [0:W-1]      in_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:W-1]      out_y,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic              busy
);
    localparam int PW = W + TAG_W + 1;

    logic [0:W-1]   fn_y;
    logic           fn_err;
    logic           vld_pipe [STAGES:0];
    logic           rdy_pipe [STAGES:0];
    logic [PW-1:0]  dat_pipe [STAGES:0];
    logic [STAGES-1:0] stage_vld;

    always_comb begin
        fn_y   = '0;
        fn_err = 1'b0;
        case (in_mode)
            MODE_MAJ: fn_y = (in_a & in_b) ^ (in_a & in_c) ^ (in_b & in_c);
            MODE_CH:  fn_y = (in_a & in_b) ^ (~in_a & in_c);
`ifdef SHA_BOOLFN_PARITY_EN
            MODE_PAR: fn_y = in_a ^ in_b ^ in_c;
`else
            MODE_PAR: fn_err = 1'b1;
`endif
            default:  fn_err = 1'b1;
        endcase
    end

    assign vld_pipe[0]      = in_valid;
    assign dat_pipe[0]      = {fn_err, in_tag, fn_y};
    assign rdy_pipe[STAGES] = out_ready;
    assign in_ready         = rdy_pipe[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        sha_pipe_stage #(.PW(PW)) u_stage (
            .clk_i   (CLK),
            .rst_n_i (RST_N),
            .valid_i (vld_pipe[k]),
            .ready_o (rdy_pipe[k]),
            .data_i  (dat_pipe[k]),
            .valid_o (vld_pipe[k+1]),
            .ready_i (rdy_pipe[k+1]),
            .data_o  (dat_pipe[k+1])
        );
        assign stage_vld[k] = vld_pipe[k+1];
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_y     = dat_pipe[STAGES][W-1:0];
    assign out_tag   = dat_pipe[STAGES][W+TAG_W-1:W];
    assign out_err   = dat_pipe[STAGES][PW-1];
    assign busy      = |stage_vld;
endmodule

// File: tb/tb_sha_bool_fn_pipe.sv
// Directed bench: vector table on the default build plus stall/flush/W=64 sequences.
module tb_sha_bool_fn_pipe;
    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [1:0]  in_mode;
    logic [3:0]  in_tag, out_tag;
    logic [0:31] in_a, in_b, in_c, out_y;

    logic        d_valid, d_in_ready, d_out_valid, d_out_ready, d_err, d_busy;
    logic [1:0]  d_mode;
    logic [3:0]  d_tag, d_out_tag;
    logic [0:63] d_a, d_b, d_c, d_y;

    int n_pass = 0, n_total = 0;

    sha_bool_fn_pipe dut (
        .CLK(clk), .RST_N(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
        .out_err(out_err), .busy(busy)
    );

    sha_bool_fn_pipe #(.W(64), .STAGES(1), .TAG_W(4)) dut64 (
        .CLK(clk), .RST_N(rst_n), .in_valid(d_valid), .in_ready(d_in_ready),
        .in_mode(d_mode), .in_tag(d_tag), .in_a(d_a), .in_b(d_b), .in_c(d_c),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_y(d_y), .out_tag(d_out_tag),
        .out_err(d_err), .busy(d_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a, b, c;
        logic [3:0]  tag;
        logic [31:0] y;
        logic        err;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] fm(input logic [1:0] m, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] c);
        case (m)
            2'd0:    return (a & b) | (a & c) | (b & c);
            2'd1:    return (a & b) | (~a & c);
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] exp_y [$];
        logic [3:0]  exp_t [$];
        logic [31:0] ey, prev_y;
        logic [3:0]  et, prev_t;
        logic        prev_stall, seen;
        int          sent, rcvd, cyc, cnt;

        vt[0] = '{2'd0, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 4'h1, 32'hFFF0F000, 1'b0};
        vt[1] = '{2'd1, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 4'h2, 32'hFF00F0F0, 1'b0};
`ifdef SHA_BOOLFN_PARITY_EN
        vt[2] = '{2'd2, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 4'h3, 32'hF00F0FF0, 1'b0};
`else
        vt[2] = '{2'd2, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 4'h3, 32'h00000000, 1'b1};
`endif
        vt[3] = '{2'd3, 32'hFFFF0000, 32'hFF00FF00, 32'hF0F0F0F0, 4'hA, 32'h00000000, 1'b1};
        vt[4] = '{2'd0, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 4'h5, 32'hFFFFFFFF, 1'b0};
        vt[5] = '{2'd1, 32'hAAAAAAAA, 32'h12345678, 32'h9ABCDEF0, 4'h6, 32'h12345678, 1'b0};
        vt[6] = '{2'd0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 4'hF, 32'h00000000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_mode = '0; in_tag = '0;
        in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b1;
        d_valid = 1'b0; d_mode = '0; d_tag = '0; d_a = '0; d_b = '0; d_c = '0; d_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_y", 64'(out_y), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // table vectors, out_ready held 1, latency exactly 2
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mode = vt[i].mode; in_tag = vt[i].tag;
            in_a = vt[i].a; in_b = vt[i].b; in_c = vt[i].c;
            #1 chk("tbl_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            chk("tbl_lat1_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
            chk("tbl_valid", 64'(out_valid), 64'd1);
            chk("tbl_y", 64'(out_y), 64'(vt[i].y));
            chk("tbl_tag", 64'(out_tag), 64'(vt[i].tag));
            chk("tbl_err", 64'(out_err), 64'(vt[i].err));
        end
        @(negedge clk);
        chk("tbl_drained", 64'(out_valid), 64'd0);

        // stream of 8 words with out_ready pattern 1,0,0,...
        sent = 0; rcvd = 0; cyc = 0; cnt = 0; prev_stall = 1'b0; prev_y = '0; prev_t = '0;
        while (rcvd < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc % 3 == 0);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_mode  = (sent % 2 == 1) ? 2'd1 : 2'd0;
                in_tag   = 4'(sent);
                in_a     = 32'h9E3779B9 * 32'(sent + 1);
                in_b     = ~(32'h9E3779B9 * 32'(sent + 1)) ^ (32'(sent) << 4);
                in_c     = 32'hF0F0F0F0 ^ 32'(sent * 32'h01010101);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("str_stall_y", 64'(out_y), 64'(prev_y));
                chk("str_stall_tag", 64'(out_tag), 64'(prev_t));
            end
            chk("str_in_ready", 64'(in_ready), 64'((cnt < 2) || out_ready));
            chk("str_busy", 64'(busy), 64'(cnt != 0));
            if (out_valid && out_ready) begin
                if (exp_t.size() == 0) begin
                    chk("str_spurious", 64'(out_tag), 64'hFFFF);
                end else begin
                    et = exp_t.pop_front(); ey = exp_y.pop_front();
                    chk("str_tag", 64'(out_tag), 64'(et));
                    chk("str_y", 64'(out_y), 64'(ey));
                end
                rcvd++; cnt--;
            end
            if (in_valid && in_ready) begin
                exp_t.push_back(in_tag);
                exp_y.push_back(fm(in_mode, in_a, in_b, in_c));
                sent++; cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_y = out_y; prev_t = out_tag;
            cyc++;
        end
        chk("str_all_received", 64'(rcvd), 64'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);

        // backpressure full pipe, then simultaneous in/out transfer
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'd0; in_a = 32'hFFFF0000; in_b = 32'hFF00FF00; in_c = 32'hF0F0F0F0;
        in_tag = 4'h1;
        @(negedge clk);
        in_tag = 4'h2;
        @(negedge clk);
        in_tag = 4'h3;
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        chk("bp_out_tag", 64'(out_tag), 64'h1);
        @(negedge clk);
        chk("bp_hold_tag", 64'(out_tag), 64'h1);
        out_ready = 1'b1;
        #1 chk("bp_ready_through", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_sim_out_tag", 64'(out_tag), 64'h2);
        chk("bp_sim_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("bp_third_tag", 64'(out_tag), 64'h3);
        chk("bp_third_y", 64'(out_y), 64'hFFF0F000);
        @(negedge clk);
        chk("bp_empty", 64'(busy), 64'd0);

        // reset flush with two words in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 4'h9;
        @(negedge clk);
        in_tag = 4'hC;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_tag", 64'(out_tag), 64'd0);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_never_out", 64'(seen), 64'd0);

        // W=64, STAGES=1
        d_valid = 1'b1; d_mode = 2'd0; d_tag = 4'h3;
        d_a = '1; d_b = '0; d_c = '1;
        #1 chk("w64_pre_valid", 64'(d_out_valid), 64'd0);
        @(negedge clk);
        chk("w64_maj_valid", 64'(d_out_valid), 64'd1);
        chk("w64_maj_y", 64'(d_y), 64'hFFFFFFFFFFFFFFFF);
        chk("w64_maj_tag", 64'(d_out_tag), 64'h3);
        d_mode = 2'd3; d_tag = 4'h5;
        @(negedge clk);
        d_valid = 1'b0;
        chk("w64_rsv_y", 64'(d_y), 64'd0);
        chk("w64_rsv_err", 64'(d_err), 64'd1);
        chk("w64_rsv_tag", 64'(d_out_tag), 64'h5);
        @(negedge clk);
        chk("w64_idle", 64'(d_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
